// File: rtl/phys_reg_free_list.sv
// Checkpointed circular free list of physical register tags for rename.
// Optional same-cycle enqueue-to-dequeue bypass when empty: FREE_LIST_BYPASS_EN.
module phys_reg_free_list #(
    parameter int FREE_LIST_DEPTH    = 32,
    parameter int NUM_PHYS_REGS      = 64,
    parameter int CHECKPOINT_COLUMNS = 4
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    output logic                                  dequeue_valid,
    output logic [$clog2(NUM_PHYS_REGS)-1:0]      dequeue_phys_reg_tag,
    input  logic                                  dequeue_req,
    input  logic                                  enqueue_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0]      enqueue_phys_reg_tag,
    input  logic                                  save_valid,
    input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] save_column,
    input  logic                                  restore_valid,
    input  logic [$clog2(CHECKPOINT_COLUMNS)-1:0] restore_column,
    output logic                                  full,
    output logic                                  overflow_err
);

    localparam int TAG_W = $clog2(NUM_PHYS_REGS);
    localparam int IDX_W = $clog2(FREE_LIST_DEPTH);
    localparam int PTR_W = IDX_W + 1;

    typedef logic [TAG_W-1:0] phys_reg_tag_t;
    typedef logic [PTR_W-1:0] free_ptr_t;

    phys_reg_tag_t entries [FREE_LIST_DEPTH];
    free_ptr_t     columns [CHECKPOINT_COLUMNS];
    free_ptr_t     head;
    free_ptr_t     tail;
    free_ptr_t     head_next;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             empty;
    logic             deq_fire;
    logic             enq_fire;
    logic             bypass_fire;

    assign head_idx = head[IDX_W-1:0];
    assign tail_idx = tail[IDX_W-1:0];
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[PTR_W-1] != tail[PTR_W-1]);

`ifdef FREE_LIST_BYPASS_EN
    // An empty list forwards the incoming tag; if consumed it is never stored.
    assign bypass_fire          = empty && enqueue_valid && dequeue_req && !restore_valid;
    assign dequeue_valid        = !empty || enqueue_valid;
    assign dequeue_phys_reg_tag = empty ? enqueue_phys_reg_tag : entries[head_idx];
`else
    assign bypass_fire          = 1'b0;
    assign dequeue_valid        = !empty;
    assign dequeue_phys_reg_tag = entries[head_idx];
`endif

    assign deq_fire = dequeue_req && !empty && !restore_valid;
    assign enq_fire = enqueue_valid && !full && !bypass_fire;

    always_comb begin
        head_next = head;
        if (restore_valid) begin
            head_next = columns[restore_column];
        end else if (deq_fire) begin
            head_next = head + PTR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < FREE_LIST_DEPTH; i++) begin
                entries[i] <= phys_reg_tag_t'(NUM_PHYS_REGS - FREE_LIST_DEPTH + i);
            end
            for (int c = 0; c < CHECKPOINT_COLUMNS; c++) begin
                columns[c] <= '0;
            end
            head         <= '0;
            tail         <= {1'b1, {IDX_W{1'b0}}};
            overflow_err <= 1'b0;
        end else begin
            head <= head_next;
            if (enq_fire) begin
                entries[tail_idx] <= enqueue_phys_reg_tag;
                tail              <= tail + PTR_W'(1);
            end
            if (enqueue_valid && full) begin
                overflow_err <= 1'b1;
            end
            // Save sees the post-dequeue / post-restore head.
            if (save_valid) begin
                columns[save_column] <= head_next;
            end
        end
    end

endmodule

// File: doc/phys_reg_free_list.md
# phys_reg_free_list

Checkpointed circular free list of physical register tags for the rename/dispatch stage. It supplies one free `phys_reg_tag_t` per cycle to dispatch for a renamed destination. It accepts one freed tag per cycle from the ROB: the old safe tag on commit, or the speculated tag on a kill. It saves and restores its head pointer per checkpoint column so that BRU mispredict recovery reclaims all tags allocated after the branch in one cycle.

## Interface
- `FREE_LIST_DEPTH`, 32: entries; equals NUM_PHYS_REGS - NUM_ARCH_REGS.
- `NUM_PHYS_REGS`, 64: tag width is $clog2(NUM_PHYS_REGS).
- `CHECKPOINT_COLUMNS`, 4: saved head pointers.
- `CLK` input 1: clock, rising edge.
- `RST` input 1: reset, asynchronous, active-high.
- `dequeue_valid` output 1: a free tag is available.
- `dequeue_phys_reg_tag` output 6: tag at head.
- `dequeue_req` input 1: dispatch consumes the head tag this cycle.
- `enqueue_valid` input 1: ROB frees a tag this cycle.
- `enqueue_phys_reg_tag` input 6: freed tag.
- `save_valid` input 1: checkpoint the head pointer.
- `save_column` input 2: `checkpoint_column_t` to write.
- `restore_valid` input 1: restore the head pointer.
- `restore_column` input 2: column to read.
- `full` output 1: all entries are free.
- `overflow_err` output 1: sticky; an enqueue was attempted while full.

## Operation
- Storage: array of FREE_LIST_DEPTH tags. `head` and `tail` are $clog2(FREE_LIST_DEPTH)+1 bits; the extra msb is the wrap bit.
- Empty: `head == tail`. Full: low bits equal and msbs differ.
- Reset state:
  - entry i = 32+i (tags 32..63); tags 0..31 are the initial arch mappings.
  - `head` = 0, `tail` = 6'b100000, so the list is full.
  - All checkpoint columns = 0. `overflow_err` = 0.
- Dequeue: when `dequeue_req && dequeue_valid`, `head` increments mod 2×DEPTH. A `dequeue_req` while empty is ignored.
- Enqueue: when `enqueue_valid && !full`, write the entry at `tail` and increment `tail`. An enqueue while full is dropped and sets `overflow_err`.
- Save: when `save_valid`, column[`save_column`] receives the head value *after* any same-cycle dequeue.
- Restore: when `restore_valid`, `head` receives column[`restore_column`].
  - Restore takes priority over dequeue; the same-cycle `dequeue_req` has no effect.
  - A same-cycle enqueue still advances `tail` normally.
- Save and restore in the same cycle: the restore applies to `head`. The save writes the restored head value into `save_column`.
- The ROB never issues a kill-free for any tag that a checkpoint restore reclaims. Upstream guarantees this; it is not checked here.
- The checkpoint system guarantees that the restored column holds a head pointer within the current [head-allocated window]. This is not checked.

## Timing
- `dequeue_valid`, `dequeue_phys_reg_tag` and `full` are combinational from registered state, with no input-to-output path (except under the macro below).
- All state updates take effect at the next rising `CLK`.
- A freed tag is dequeuable in the cycle after enqueue.
- Back-to-back dequeue every cycle is supported at 1 tag per cycle, including across pointer wrap.
- Simultaneous enqueue and dequeue while full or empty:
  - Empty: the dequeue is ignored and the enqueue proceeds.
  - Full: the dequeue proceeds, but the enqueue is still dropped because full is evaluated on pre-cycle state.
- `RST` asserted mid-operation returns every register to its reset state immediately, regardless of `CLK`.

## Configuration
- `FREE_LIST_BYPASS_EN` defined:
  - When empty and `enqueue_valid`, `dequeue_valid`=1 and `dequeue_phys_reg_tag`=`enqueue_phys_reg_tag` in the same cycle.
  - If `dequeue_req` is also high, the tag is consumed without being written. Neither `head` nor `tail` moves.
- `FREE_LIST_BYPASS_EN` undefined:
  - Behaves as described in Operation; the enqueued tag appears one cycle later.
  - No combinational path from `enqueue_*` to `dequeue_*`.

## Test plan
- Reset then 32 consecutive `dequeue_req` → tags 32,33,…,63 in order; `dequeue_valid`=0 after the 32nd; `full` is 1 only before the first dequeue.
- After draining: enqueue 5, next cycle dequeue → tag 5. Under `FREE_LIST_BYPASS_EN`, the same-cycle dequeue returns 5 and the list stays empty.
- Dequeue 3 (32,33,34), `save_valid` col 2, dequeue 4 (35..38), `restore_valid` col 2 → next tag is 35 and `dequeue_valid`=1.
- Restore with simultaneous `dequeue_req` and enqueue of tag 7 → `head` equals the saved value, `tail` advances by 1, and tag 7 is present after the wrap.
- Enqueue while full (immediately after reset) → entry unchanged, `overflow_err`=1 and sticky until `RST`.
- Drain/refill 3 times to cross the wrap bit → FIFO order preserved; `RST` pulse mid-stream restores tags 32..63 and `full`=1 asynchronously.
